// File: rtl/pwm_if.sv
// Configuration and output bundle between the control block and the PWM core.
// The master drives the static configuration and run control; the slave (the PWM) drives pwmout.
interface pwm_if;
  logic       enable;
  logic [7:0] cycle_on;
  logic [7:0] period;
  logic [1:0] pre;
  logic       pwmout;

  modport master (
    output enable,
    output cycle_on,
    output period,
    output pre,
    input  pwmout
  );

  modport slave (
    input  enable,
    input  cycle_on,
    input  period,
    input  pre,
    output pwmout
  );
endinterface

// File: rtl/pwm.sv
// Single-channel 8-bit PWM with a 2-bit clock prescaler (tick every 2^pre clocks).
// Optional macro PWM_SHADOW_EN: period/cycle_on are latched at period boundaries, so no runt pulses.
module pwm (
  input  logic  clk,
  input  logic  rst,
  pwm_if.slave  bus
);

  logic [2:0] pre_cnt;
  logic [2:0] pre_term;
  logic       tick;
  logic [7:0] cnt;
  logic [7:0] period_eff;
  logic [7:0] cycle_on_eff;
  logic       wrap;
  logic       pwm_q;

  always_comb begin
    pre_term = 3'd0;
    case (bus.pre)
      2'b00:   pre_term = 3'd0;
      2'b01:   pre_term = 3'd1;
      2'b10:   pre_term = 3'd3;
      default: pre_term = 3'd7;
    endcase
  end

  // ">=" rather than "==" so that lowering pre mid-run wraps immediately with a tick.
  assign tick = (pre_cnt >= pre_term);
  assign wrap = tick && (cnt == period_eff - 8'd1);

`ifdef PWM_SHADOW_EN
  logic shadow_load;

  assign shadow_load = !bus.enable || (period_eff == 8'd0) || wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_eff   <= 8'd0;
      cycle_on_eff <= 8'd0;
    end else if (shadow_load) begin
      period_eff   <= bus.period;
      cycle_on_eff <= bus.cycle_on;
    end
  end
`else
  assign period_eff   = bus.period;
  assign cycle_on_eff = bus.cycle_on;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= 3'd0;
    end else if (!bus.enable || tick) begin
      pre_cnt <= 3'd0;
    end else begin
      pre_cnt <= pre_cnt + 3'd1;
    end
  end

  // A period lowered below cnt is caught by the natural 8-bit rollover.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 8'd0;
    end else if (!bus.enable || (period_eff == 8'd0)) begin
      cnt <= 8'd0;
    end else if (tick) begin
      if (wrap) begin
        cnt <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= bus.enable && (period_eff != 8'd0) && (cnt < cycle_on_eff);
    end
  end

  assign bus.pwmout = pwm_q;

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for pwm: constant table of waveform shapes, hand-written corner sequences,
// and randomized configurations checked against an arithmetic model of the output waveform.
module tb_pwm;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic [0:0] exp_q[$];

  pwm_if bus ();

  pwm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

`ifdef PWM_SHADOW_EN
  localparam int RST_OFFSET = 1;
`else
  localparam int RST_OFFSET = 0;
`endif

  // ---------------- reference model ----------------
  // j = enabled clocks since the run (re)started; cnt advances once every 2^pre clocks.
  function automatic logic model_bit(int j, int p, int c, int pre_sel);
    if (j < 0 || p == 0) return 1'b0;
    return ((j >> pre_sel) % p) < c;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic compare(string name, logic act);
    logic [0:0] exp;
    exp = exp_q.pop_front();
    vectors++;
    if (act !== exp[0]) begin
      miscompares++;
      $display("FAIL %s: pwmout=%0b expected %0b at %0t", name, act, exp[0], $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cfg(int p, int c, int pre_sel);
    bus.period   = 8'(p);
    bus.cycle_on = 8'(c);
    bus.pre      = 2'(pre_sel);
  endtask

  // Ends on a negedge with enable just raised; the next posedge is the first enabled edge.
  task automatic restart(int p, int c, int pre_sel);
    @(negedge clk);
    bus.enable = 1'b0;
    set_cfg(p, c, pre_sel);
    repeat (2) @(negedge clk);
    bus.enable = 1'b1;
  endtask

  task automatic check_edges(string name, int n, int p, int c, int pre_sel, int j0, int offset);
    for (int k = 1; k <= n; k++) begin
      exp_q.push_back(model_bit(j0 + k - 1 - offset, p, c, pre_sel));
      @(negedge clk);
      compare(name, bus.pwmout);
    end
  endtask

  task automatic expect_const(string name, logic v);
    exp_q.push_back(v);
    compare(name, bus.pwmout);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int p;
    int c;
    int pre_sel;
    int high_clks;
    int low_clks;
    int cycles;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{200, 150, 0, 150, 50, 400};
    tbl[1] = '{10, 3, 2, 12, 28, 80};
    tbl[2] = '{10, 3, 3, 24, 56, 160};
    tbl[3] = '{200, 0, 0, 0, 16, 64};
    tbl[4] = '{200, 200, 0, 200, 0, 400};
    tbl[5] = '{10, 255, 0, 10, 0, 40};
    tbl[6] = '{0, 50, 0, 0, 16, 64};

    // Reset and duty: pwmout low during reset, then 150 high / 50 low for 200 us.
    rst = 1'b0;
    bus.enable = 1'b1;
    set_cfg(200, 150, 0);
    #1 expect_const("reset_start", 1'b0);
    #6 expect_const("reset_hold", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    check_edges("duty", 20000, 200, 150, 0, 0, RST_OFFSET);

    // Table of waveform shapes: high_clks high then low_clks low, repeating.
    for (int i = 0; i < 7; i++) begin
      restart(tbl[i].p, tbl[i].c, tbl[i].pre_sel);
      for (int k = 1; k <= tbl[i].cycles; k++) begin
        exp_q.push_back(((k - 1) % (tbl[i].high_clks + tbl[i].low_clks)) < tbl[i].high_clks);
        @(negedge clk);
        compare($sformatf("table_%0d", i), bus.pwmout);
      end
    end

    // Enable dropped mid high phase, then raised: full-length high phase again.
    restart(200, 150, 0);
    check_edges("en_before", 50, 200, 150, 0, 0, 0);
    bus.enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      expect_const("en_drop", 1'b0);
    end
    bus.enable = 1'b1;
    check_edges("en_restart", 400, 200, 150, 0, 0, 0);

    // Asynchronous reset between edges clears the output without a clock edge.
    restart(200, 150, 0);
    check_edges("rst_before", 30, 200, 150, 0, 0, 0);
    #2 rst = 1'b0;
    #1 expect_const("async_rst", 1'b0);
    @(negedge clk);
    expect_const("async_rst_hold", 1'b0);
    rst = 1'b1;
    check_edges("post_rst", 400, 200, 150, 0, 0, RST_OFFSET);

    // cycle_on changed 150 -> 50 at cnt=20.
    restart(200, 150, 0);
    check_edges("mid_before", 20, 200, 150, 0, 0, 0);
    bus.cycle_on = 8'd50;
    for (int k = 21; k <= 400; k++) begin
      int c_now;
`ifdef PWM_SHADOW_EN
      c_now = ((k - 1) < 200) ? 150 : 50;
`else
      c_now = 50;
`endif
      exp_q.push_back(model_bit(k - 1, 200, c_now, 0));
      @(negedge clk);
      compare("mid_change", bus.pwmout);
    end

    // Randomized configurations against the arithmetic model.
    for (int r = 0; r < 25; r++) begin
      int p;
      int c;
      int pr;
      int n;
      p  = $urandom_range(0, 40);
      c  = $urandom_range(0, 50);
      pr = $urandom_range(0, 3);
      n  = (p == 0) ? 20 : (2 * p * (1 << pr) + 3);
      restart(p, c, pr);
      check_edges($sformatf("rand_p%0d_c%0d_pre%0d", p, c, pr), n, p, c, pr, 0, 0);
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
